bcd_updown_seg_counter: RTL

- Parametrised multi-digit BCD up/down counter with a built-in tick prescaler and a time-multiplexed 7-segment display driver.
- It is the next-generation counter/display block for the Vaman board, replacing the fixed single-digit increment-and-decode logic.
- Adds direction control, enable, parallel load, wrap flag, configurable digit count and scan rate, and selectable output polarity.

---
 rtl/bcd_updown_seg_counter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/bcd_updown_seg_counter.sv
// Multi-digit BCD up/down counter with tick prescaler, parallel load and a
// time-multiplexed 7-segment scan driver (seg/digit_sel registered, 1-cycle latency).
module bcd_updown_seg_counter #(
  parameter int NUM_DIGITS     = 4,
  parameter int TICK_DIV       = 6000000,
  parameter int SCAN_DIV       = 6000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    up_dn,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    tick,
  output logic                    wrap,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   digit_sel
);

  localparam int CW = 4 * NUM_DIGITS;
  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  localparam logic [6:0] GLYPH_ZERO = 7'b1111110;
  localparam logic [6:0] SEG_RST    = SEG_ACTIVE_LOW ? ~GLYPH_ZERO : GLYPH_ZERO;
  localparam logic [NUM_DIGITS-1:0] DIG_ONE = NUM_DIGITS'(1);
  localparam logic [NUM_DIGITS-1:0] DIG_RST = DIG_ACTIVE_LOW ? ~DIG_ONE : DIG_ONE;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b1111110;
      4'd1:    glyph = 7'b0110000;
      4'd2:    glyph = 7'b1101101;
      4'd3:    glyph = 7'b1111001;
      4'd4:    glyph = 7'b0110011;
      4'd5:    glyph = 7'b1011011;
      4'd6:    glyph = 7'b1011111;
      4'd7:    glyph = 7'b1110000;
      4'd8:    glyph = 7'b1111111;
      4'd9:    glyph = 7'b1111011;
      default: glyph = 7'b1111110;
    endcase
  endfunction

  logic [PW-1:0] presc;
  logic [SW-1:0] scan_cnt;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_next;
  logic [CW-1:0] step_val;
  logic [CW-1:0] load_clean;
  logic          step_wrap;
  logic          carry;
  logic [3:0]    nib;
  logic [3:0]    cur_nib;
  logic [6:0]    raw_seg;
  logic [NUM_DIGITS-1:0] onehot;

  // Ripple carry/borrow through the digits; carry out of the top digit is the wrap.
  always_comb begin
    step_val = count;
    carry    = 1'b1;
    nib      = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib = count[4*i +: 4];
      if (carry) begin
        if (up_dn) begin
          if (nib == 4'd9) step_val[4*i +: 4] = 4'd0;
          else begin
            step_val[4*i +: 4] = nib + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (nib == 4'd0) step_val[4*i +: 4] = 4'd9;
          else begin
            step_val[4*i +: 4] = nib - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
    step_wrap = carry;
  end

  always_comb begin
    load_clean = load_val;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) load_clean[4*i +: 4] = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      count <= '0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
      if (load) begin
        count <= load_clean;
        presc <= '0;
      end else if (en) begin
        if (presc == PRE_LAST) begin
          presc <= '0;
          count <= step_val;
          tick  <= 1'b1;
          wrap  <= step_wrap;
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

  // Display decodes the pre-edge count at the index that becomes current on this edge.
  always_comb begin
    idx_next = idx;
    if (scan_cnt == SCAN_LAST) idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    cur_nib = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IW'(i) == idx_next) cur_nib = count[4*i +: 4];
    end
    raw_seg = glyph(cur_nib);
    onehot  = DIG_ONE << idx_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt  <= '0;
      idx       <= '0;
      seg       <= SEG_RST;
      digit_sel <= DIG_RST;
    end else begin
      scan_cnt  <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + 1'b1;
      idx       <= idx_next;
      seg       <= SEG_ACTIVE_LOW ? ~raw_seg : raw_seg;
      digit_sel <= DIG_ACTIVE_LOW ? ~onehot : onehot;
    end
  end

endmodule
